// File: rtl/ram_1p_obi_arbiter_if.sv
// Bus bundle for the single-port RAM front end: instruction and load/store request
// channels, their rvalid responses, and the RAM-side access port.
interface ram_1p_obi_arbiter_if #(
   parameter int AW = 14
) ();
   logic          instr_req_i;
   logic [31:0]   instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [31:0]   instr_rdata_o;
   logic          instr_err_o;

   logic          data_req_i;
   logic [31:0]   data_addr_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [31:0]   data_rdata_o;
   logic          data_err_o;

   logic          ram_valid_o;
   logic [AW-1:0] ram_addr_o;
   logic [3:0]    ram_we_o;
   logic [31:0]   ram_wdata_o;
   logic [31:0]   ram_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output ram_valid_o, ram_addr_o, ram_we_o, ram_wdata_o,
      input  ram_rdata_i
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  ram_valid_o, ram_addr_o, ram_we_o,ram_wdata_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/ram_1p_obi_arbiter.sv
// Round-robin arbiter placing fetch and load/store requests onto one RAM port, with
// range checking and fixed one-cycle rvalid responses routed back to the winning port.
module ram_1p_obi_arbiter #(
   parameter int          SIZE      = 16384,
   parameter int          AW        = 14,
   parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
   input logic                 clk_i,
   input logic                 rst_i,
   ram_1p_obi_arbiter_if.slave bus
);

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   // 33-bit bounds so a window ending at 4 GiB does not wrap
   localparam logic [32:0]   RANGE_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0]   RANGE_HI = RANGE_LO + (33'(SIZE) << 2);
   localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];

   logic        gnt_instr;
   logic        gnt_data;
   logic        granted;
   logic        sel_store;
   logic        in_range;
   logic [31:0] sel_addr;

   logic        last_data;
   logic        resp_valid;
   port_e       resp_port;
   logic        resp_err;
   logic        resp_read;
   logic [31:0] resp_rdata;

   always_comb begin
      gnt_instr = 1'b0;
      gnt_data  = 1'b0;
      if (!rst_i) begin
         if (bus.instr_req_i && bus.data_req_i) begin
            gnt_instr = last_data;
            gnt_data  = !last_data;
         end else begin
            gnt_instr = bus.instr_req_i;
            gnt_data  = bus.data_req_i;
         end
      end
      granted   = gnt_instr || gnt_data;
      sel_addr  = gnt_instr ? bus.instr_addr_i : bus.data_addr_i;
      sel_store = gnt_data && bus.data_we_i;
      in_range  = ({1'b0, sel_addr} >= RANGE_LO) && ({1'b0, sel_addr} < RANGE_HI);
   end

   assign bus.instr_gnt_o = gnt_instr;
   assign bus.data_gnt_o  = gnt_data;

   // BASE_ADDR is word aligned, so the word index is a plain subtraction of index bits
   assign bus.ram_valid_o = granted && in_range;
   assign bus.ram_addr_o  = sel_addr[AW+1:2] - BASE_IDX;
   assign bus.ram_we_o    = (granted && in_range && sel_store) ? bus.data_be_i : '0;
   assign bus.ram_wdata_o = bus.data_wdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_data  <= 1'b0;
         resp_valid <= 1'b0;
         resp_port  <= PORT_INSTR;
         resp_err   <= 1'b0;
         resp_read  <= 1'b0;
      end else begin
         resp_valid <= granted;
         resp_port  <= gnt_data ? PORT_DATA : PORT_INSTR;
         resp_err   <= granted && !in_range;
         resp_read  <= granted && !sel_store;
         if (granted) begin
            last_data <= gnt_data;
         end
      end
   end

   assign resp_rdata = (!rst_i && resp_valid && resp_read && !resp_err) ? bus.ram_rdata_i : '0;

   assign bus.instr_rvalid_o = !rst_i && resp_valid && (resp_port == PORT_INSTR);
   assign bus.instr_err_o    = !rst_i && resp_valid && (resp_port == PORT_INSTR) && resp_err;
   assign bus.instr_rdata_o  = (resp_port == PORT_INSTR) ? resp_rdata : '0;

   assign bus.data_rvalid_o  = !rst_i && resp_valid && (resp_port == PORT_DATA);
   assign bus.data_err_o     = !rst_i && resp_valid && (resp_port == PORT_DATA) && resp_err;
   assign bus.data_rdata_o   = (resp_port == PORT_DATA) ? resp_rdata : '0;

endmodule

// File: doc/ram_1p_obi_arbiter.md
# ram_1p_obi_arbiter

Request-side front end for the single-port simulation RAM. Accepts the core's instruction-fetch and load/store bus requests (req/gnt/rvalid protocol), arbitrates them onto the one RAM port, translates byte addresses to word indices and byte enables, and routes the one-cycle-latency read data back as rvalid responses. It flags out-of-range addresses with an error response and never touches the RAM for them.

## Interface
- SIZE, 16384, RAM depth in 32-bit words
- AW, 14, RAM word-address width; must equal $clog2(SIZE)
- BASE_ADDR, 32'h0010_0000, byte address of RAM word 0; 4-byte aligned

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch response is an error
- data_req_i  in  1  load/store request
- data_addr_i  in  32  load/store byte address
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store accepted this cycle
- data_rvalid_o  out  1  load/store response valid (loads and stores)
- data_rdata_o  out  32  load data
- data_err_o  out  1  load/store response is an error
- ram_valid_o  out  1  RAM access enable
- ram_addr_o  out  AW  RAM word index
- ram_we_o  out  4  RAM per-byte write enables
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_valid_o

## Operation
- At most one grant per cycle. Grants are combinational from the current request; gnt is never asserted without req.
- Arbitration: only one port requesting -> grant it. Both requesting -> round-robin on register last_data (1 = data port won the most recent contested or uncontested grant); grant instr if last_data=1, else data. last_data updates on every grant. Reset value 0, so the first tie goes to data.
- Range check on the granted address: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*SIZE), computed in 33 bits so no wrap at the top of memory. addr[1:0] ignored.
- Granted and in range: ram_valid_o=1, ram_addr_o=(addr-BASE_ADDR)[AW+1:2]. Data store: ram_we_o=data_be_i, ram_wdata_o=data_wdata_i. Load or fetch: ram_we_o=4'b0. A store with data_be_i=0 is a legal no-op write with a normal response.
- Granted and out of range: ram_valid_o=0, ram_we_o=0; response carries err=1.
- No grant: ram_valid_o=0, ram_we_o=0; ram_addr_o/ram_wdata_o don't-care.
- Response registers: resp_valid, resp_port (0 instr / 1 data), resp_err, resp_read, all loaded every cycle from the current grant.
- Response cycle: rvalid_o of resp_port = resp_valid; err_o = resp_err; rdata_o = ram_rdata_i if resp_read && !resp_err, else 32'h0. Outputs of the non-selected port are 0.

## Timing
- Grant in cycle N -> RAM samples at end of N -> rvalid/rdata/err in N+1. Fixed latency 1 for hits and errors alike.
- Fully pipelined: one grant per cycle, back-to-back, mixed ports; responses return in grant order, one per cycle, never stalled (no response backpressure exists).
- Store followed by load to the same word in consecutive cycles: load returns the new data (RAM is write-then-read per word).
- Reset: while rst_i=1, all gnt_o, rvalid_o, err_o, ram_valid_o, ram_we_o are 0, rdata_o are 0; response registers and last_data clear on the reset edge. Request granted in the cycle rst_i rises gets no response; first response possible in the second cycle after rst_i falls.
- Requester holding req without grant keeps addr/we/be/wdata stable; the block does not latch unaccepted requests.

## Test plan
- Reset with both req=1 -> no gnt, no ram_valid_o, no rvalid; first cycle after release both req -> data_gnt_o=1, instr_gnt_o=0.
- Data store addr 32'h0010_0010, be=4'b0101, wdata=32'hAABBCCDD over word 32'h11223344 at index 4 -> ram_addr_o=4, ram_we_o=4'b0101; next cycle data_rvalid_o=1, err=0; later load returns 32'h11BB33DD.
- Fetch at 32'h0010_0000 -> gnt same cycle, instr_rvalid_o next cycle with preloaded word 0; data_rvalid_o stays 0.
- Both ports request continuously for 8 cycles -> grants alternate data, instr, data, ...; 8 responses in grant order, 1 per cycle.
- Addresses 32'h000F_FFFC, 32'h0011_0000 (= BASE+4*SIZE), 32'hFFFF_FFFC -> gnt, ram_valid_o=0, next cycle err=1, rdata=0; 32'h0010_FFFC -> normal hit, index 16383.
- rst_i asserted in the cycle of a granted load -> no rvalid in the following cycle; normal operation resumes after release.
